// File: rtl/bk_pkg.sv
// Shared Brent-Kung prefix helpers: pipeline depth limit and the black-cell merge.
package bk_pkg;

  localparam int BK_MAX_PIPE = 4;

  // Merge upper group (g_hi,p_hi) with adjacent lower group (g_lo,p_lo).
  // Returns {G,P}; the gray cell uses only the G bit.
  function automatic logic [1:0] bk_black(input logic g_hi, input logic p_hi,
                                          input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

endpackage

// File: rtl/black_cell_par_if.sv
// Operand/result bundle for the registered black cell.
interface black_cell_par_if #(parameter int WIDTH = 1);
  logic             in_valid;
  logic [WIDTH-1:0] Gi;
  logic [WIDTH-1:0] Pi;
  logic [WIDTH-1:0] Gk;
  logic [WIDTH-1:0] Pk;
  logic [WIDTH-1:0] Go;
  logic [WIDTH-1:0] Po;
  logic             out_valid;

  modport master (output in_valid, Gi, Pi, Gk, Pk, input  Go, Po, out_valid);
  modport slave  (input  in_valid, Gi, Pi, Gk, Pk, output Go, Po, out_valid);
endinterface

// File: rtl/black_cell_par_comb.sv
// Combinational black cell, WIDTH independent lanes.
module black_cell_comb
  import bk_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] gi,
  input  logic [WIDTH-1:0] pi,
  input  logic [WIDTH-1:0] gk,
  input  logic [WIDTH-1:0] pk,
  output logic [WIDTH-1:0] go,
  output logic [WIDTH-1:0] po
);

  for (genvar n = 0; n < WIDTH; n++) begin : g_lane
    logic [1:0] gp;
    // Each lane is a self-contained merge; no cross-lane terms.
    always_comb gp = bk_black(gi[n], pi[n], gk[n], pk[n]);
    assign go[n] = gp[1];
    assign po[n] = gp[0];
  end

endmodule

// File: rtl/black_cell_par.sv
// Registered black cell: combinational merge followed by PIPE_STAGES flop stages.
module black_cell_par
  import bk_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  black_cell_par_if.slave  bus
);

  if (PIPE_STAGES < 1 || PIPE_STAGES > BK_MAX_PIPE) begin : g_bad_pipe
    $error("black_cell_par: PIPE_STAGES=%0d outside 1..%0d", PIPE_STAGES, BK_MAX_PIPE);
  end

  logic [WIDTH-1:0] g_c, p_c;

  // Stage s holds the result sampled s-1 edges ago; stage PIPE_STAGES drives the outputs.
  logic [PIPE_STAGES:1]                vld_pipe;
  logic [PIPE_STAGES:1][WIDTH-1:0]     g_pipe;
  logic [PIPE_STAGES:1][WIDTH-1:0]     p_pipe;

  black_cell_comb #(.WIDTH(WIDTH)) u_comb (
    .gi (bus.Gi),
    .pi (bus.Pi),
    .gk (bus.Gk),
    .pk (bus.Pk),
    .go (g_c),
    .po (p_c)
  );

  // Shift data and valid together every cycle; data loads even when invalid so
  // outputs stay deterministic. Reset flushes every in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      g_pipe   <= '0;
      p_pipe   <= '0;
    end else begin
      vld_pipe[1] <= bus.in_valid;
      g_pipe[1]   <= g_c;
      p_pipe[1]   <= p_c;
      for (int s = 2; s <= PIPE_STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        g_pipe[s]   <= g_pipe[s-1];
        p_pipe[s]   <= p_pipe[s-1];
      end
    end
  end

  assign bus.Go        = g_pipe[PIPE_STAGES];
  assign bus.Po        = p_pipe[PIPE_STAGES];
  assign bus.out_valid = vld_pipe[PIPE_STAGES];

endmodule

// File: tb/tb_black_cell_par.sv
// Bench for black_cell_par: three instances cover (W=1,PS=1), (W=4,PS=2), (W=4,PS=3).
module tb_black_cell_par;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  black_cell_par_if #(.WIDTH(1)) if1 ();
  black_cell_par_if #(.WIDTH(4)) if2 ();
  black_cell_par_if #(.WIDTH(4)) if3 ();

  black_cell_par #(.WIDTH(1), .PIPE_STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  black_cell_par #(.WIDTH(4), .PIPE_STAGES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  black_cell_par #(.WIDTH(4), .PIPE_STAGES(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  typedef struct {
    logic [3:0] gi, pi, gk, pk;
    logic [3:0] go, po;
  } vec_t;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: per-lane merge from the truth-table rules, one lane at a time.
  function automatic logic [7:0] ref_merge(input logic [3:0] gi, pi, gk, pk);
    logic [3:0] g, p;
    for (int n = 0; n < 4; n++) begin
      g[n] = (gi[n] == 1'b1) || (pi[n] == 1'b1 && gk[n] == 1'b1);
      p[n] = (pi[n] == 1'b1 && pk[n] == 1'b1);
    end
    return {g, p};
  endfunction

  task automatic idle_all();
    if1.in_valid = 0; if1.Gi = 0; if1.Pi = 0; if1.Gk = 0; if1.Pk = 0;
    if2.in_valid = 0; if2.Gi = 0; if2.Pi = 0; if2.Gk = 0; if2.Pk = 0;
    if3.in_valid = 0; if3.Gi = 0; if3.Pi = 0; if3.Gk = 0; if3.Pk = 0;
  endtask

  vec_t ex1 [16];
  vec_t ex4;
  logic [1:0] tt [16];

  logic       hv [32];
  logic [3:0] hg [32];
  logic [3:0] hp [32];

  initial begin
    idle_all();
    rst_n = 1'b0;

    // Exhaustive table: {Go,Po} for (Gi,Pi,Gk,Pk) = 0000..1111
    tt = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11,
           2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11};
    for (int i = 0; i < 16; i++) begin
      logic [3:0] b;
      b = i[3:0];
      ex1[i].gi = {3'b0, b[3]}; ex1[i].pi = {3'b0, b[2]};
      ex1[i].gk = {3'b0, b[1]}; ex1[i].pk = {3'b0, b[0]};
      ex1[i].go = {3'b0, tt[i][1]}; ex1[i].po = {3'b0, tt[i][0]};
    end
    ex4 = '{gi: 4'b0001, pi: 4'b0110, gk: 4'b0100, pk: 4'b1111, go: 4'b0101, po: 4'b0110};

    // Reset state
    #12;
    chk("rst_u1", {if1.out_valid, if1.Go, if1.Po}, 0);
    chk("rst_u2", {if2.out_valid, if2.Go, if2.Po}, 0);
    chk("rst_u3", {if3.out_valid, if3.Go, if3.Po}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Exhaustive truth table, W=1 PS=1
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if1.in_valid = 1; if1.Gi = ex1[i].gi[0]; if1.Pi = ex1[i].pi[0];
      if1.Gk = ex1[i].gk[0]; if1.Pk = ex1[i].pk[0];
      @(posedge clk); #1;
      chk($sformatf("tt%0d_v", i), if1.out_valid, 1);
      chk($sformatf("tt%0d_gp", i), {if1.Go, if1.Po}, {ex1[i].go[0], ex1[i].po[0]});
    end
    @(negedge clk) if1.in_valid = 0;
    @(posedge clk); #1;
    chk("u1_valid_drop", if1.out_valid, 0);

    // Lane independence, W=4 PS=2
    @(negedge clk);
    if2.in_valid = 1; if2.Gi = ex4.gi; if2.Pi = ex4.pi; if2.Gk = ex4.gk; if2.Pk = ex4.pk;
    @(posedge clk); #1;
    if2.in_valid = 0;
    chk("lane_mid_v", if2.out_valid, 0);
    @(posedge clk); #1;
    chk("lane_v", if2.out_valid, 1);
    chk("lane_go", if2.Go, ex4.go);
    chk("lane_po", if2.Po, ex4.po);

    // Latency, PS=3: single pulse, output only after the third edge
    @(negedge clk);
    if3.in_valid = 1; if3.Gi = 4'h0; if3.Pi = 4'hF; if3.Gk = 4'hF; if3.Pk = 4'hF;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin if3.in_valid = 0; if3.Pi = 4'h0; end
      chk($sformatf("lat_c%0d_v", c), if3.out_valid, (c == 3) ? 1 : 0);
      if (c == 3) chk("lat_gp", {if3.Go, if3.Po}, 8'hFF);
    end

    // Reset mid-flight, PS=3
    @(negedge clk);
    if3.in_valid = 1; if3.Gi = 4'hF; if3.Pi = 4'hF; if3.Gk = 4'hF; if3.Pk = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #3;
    if3.in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_v", if3.out_valid, 0);
    chk("rstmid_gp", {if3.Go, if3.Po}, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rstmid_post%0d_v", c), if3.out_valid, 0);
    end

    // Throughput, PS=2: history indexed by sample cycle, output lags by one entry
    begin
      int nvalid;
      nvalid = 0;
      for (int c = 0; c < 22; c++) begin
        @(negedge clk);
        if (c < 16) begin
          if2.in_valid = 1;
          if2.Gi = 4'($urandom); if2.Pi = 4'($urandom);
          if2.Gk = 4'($urandom); if2.Pk = 4'($urandom);
        end else begin
          if2.in_valid = 0;
        end
        hv[c] = if2.in_valid;
        {hg[c], hp[c]} = ref_merge(if2.Gi, if2.Pi, if2.Gk, if2.Pk);
        @(posedge clk); #1;
        if (c >= 1) begin
          chk($sformatf("thr%0d_v", c - 1), if2.out_valid, hv[c-1]);
          if (hv[c-1]) begin
            chk($sformatf("thr%0d_gp", c - 1), {if2.Go, if2.Po}, {hg[c-1], hp[c-1]});
          end
          if (if2.out_valid) nvalid++;
        end
      end
      chk("thr_count", nvalid, 16);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
